// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared types and constants for the register-access arbiter.
//   state_t      FSM encoding (IDLE, ACCESS, RESP)
//   NUM_REQ      number of requesters (fixed at 2)
//   DEF_DATA_W   default register data width
//   DEF_ADDR_W   default register address width
package reg_arb_pkg;

  localparam int NUM_REQ    = 2;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way winner select.
//   req  [1:0]  requests
//   ptr         last-granted requester (1 = requester 1 was last)
//   win  [1:0]  one-hot winner, zero when no request
// Macro ARB_FIXED_PRIO_EN: requester 0 always wins a tie and ptr is ignored.
// Default build: round-robin, the requester not last granted wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] win
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ptr;

  always_comb begin
    win = 2'b00;
    if (req[0])      win = 2'b01;
    else if (req[1]) win = 2'b10;
  end
`else
  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = ptr ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter: arbitrates two requesters onto one register block.
//   clk, reset          clock, synchronous active-high reset
//   req/req_wr          per-requester request and command (1 = write)
//   req_addr/req_wdata  per-requester address/data, requester i in slice i
//   gnt                 one-cycle pulse: command of requester i consumed
//   done                one-cycle pulse: access of requester i complete
//   rsp_rdata           read data, valid while a done bit is high
//   busy                FSM in ACCESS or RESP
//   reg_sel/reg_wr/reg_addr/reg_wdata  register-block command
//   reg_rdata           registered read data from the register block
// Macro ARB_FIXED_PRIO_EN: fixed priority (requester 0 wins ties), no pointer.
module reg_access_arbiter
  import reg_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      busy,
  output logic                      reg_sel,
  output logic                      reg_wr,
  output logic [ADDR_W-1:0]         reg_addr,
  output logic [DATA_W-1:0]         reg_wdata,
  input  logic [DATA_W-1:0]         reg_rdata
);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   win_q, win_d, arb_win;
  logic [NUM_REQ-1:0]   gnt_d, done_d;
  logic                 sel_d, wr_d;
  logic [ADDR_W-1:0]    addr_d;
  logic [DATA_W-1:0]    wdata_d;
  logic                 ptr_q;

  rr_arb2 u_arb (
    .req (req),
    .ptr (ptr_q),
    .win (arb_win)
  );

`ifdef ARB_FIXED_PRIO_EN
  assign ptr_q = 1'b1;
`else
  // Last-granted pointer; reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset)               ptr_q <= 1'b1;
    else if (|gnt_d)         ptr_q <= gnt_d[1];
  end
`endif

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    gnt_d   = '0;
    done_d  = '0;
    sel_d   = 1'b0;
    wr_d    = 1'b0;
    addr_d  = reg_addr;
    wdata_d = reg_wdata;
    case (state_q)
      ACCESS: begin
        done_d  = win_q;
        state_d = RESP;
      end
      IDLE, RESP: begin
        // RESP arbitrates too, giving one access every two cycles.
        if (|req) begin
          state_d = ACCESS;
          win_d   = arb_win;
          gnt_d   = arb_win;
          sel_d   = 1'b1;
          wr_d    = arb_win[1] ? req_wr[1] : req_wr[0];
          addr_d  = arb_win[1] ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          wdata_d = arb_win[1] ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      win_q     <= '0;
      gnt       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      reg_sel   <= 1'b0;
      reg_wr    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      gnt       <= gnt_d;
      done      <= done_d;
      busy      <= (state_d != IDLE);
      reg_sel   <= sel_d;
      reg_wr    <= wr_d;
      reg_addr  <= addr_d;
      reg_wdata <= wdata_d;
    end
  end

  // The register block's read data is itself registered and only lands in
  // the RESP cycle, so it is forwarded qualified by the registered done.
  assign rsp_rdata = (|done) ? reg_rdata : '0;

endmodule

// File: tb/tb_reg_access_arbiter.sv
module tb_reg_access_arbiter;

  localparam int DW = 16;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req, req_wr;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]    gnt, done;
  logic [DW-1:0] rsp_rdata;
  logic          busy, reg_sel, reg_wr;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata, reg_rdata;

  always #5 clk = ~clk;

  reg_access_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .rsp_rdata(rsp_rdata), .busy(busy), .reg_sel(reg_sel), .reg_wr(reg_wr),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  // Register block: 4 x 16 regs, reset to 0, registered read data.
  logic [DW-1:0] rf [4];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) rf[i] <= '0;
      reg_rdata <= '0;
    end else if (reg_sel) begin
      if (reg_wr) rf[reg_addr] <= reg_wdata;
      else        reg_rdata    <= rf[reg_addr];
    end
  end

  typedef struct {
    logic          rst;
    logic [1:0]    rq, wr;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic [1:0]    eg, ed;
    logic          eb, es, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    logic          crd;
    logic [DW-1:0] erd;
  } vec_t;

  vec_t tbl[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(logic rst, logic [1:0] rq, logic [1:0] wr,
                              logic [AW-1:0] a0, logic [AW-1:0] a1,
                              logic [DW-1:0] d0, logic [DW-1:0] d1,
                              logic [1:0] eg, logic [1:0] ed, logic eb,
                              logic es, logic ew, logic [AW-1:0] ea,
                              logic [DW-1:0] ewd, logic crd, logic [DW-1:0] erd);
    vec_t v;
    v.rst = rst; v.rq = rq; v.wr = wr; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.eg = eg; v.ed = ed; v.eb = eb; v.es = es; v.ew = ew; v.ea = ea;
    v.ewd = ewd; v.crd = crd; v.erd = erd;
    return v;
  endfunction

  // Idle vector: all outputs quiet, address/data hold ea/ewd.
  function automatic vec_t idle(logic [AW-1:0] ea, logic [DW-1:0] ewd);
    return mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, ea, ewd, 1, 16'h0);
  endfunction

  initial begin
    logic [1:0] g_exp;
    int n;

    // Write addr0=1234 then read it back (requester 0).
    tbl.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 16'h0, 1, 16'h0));
    tbl.push_back(mk(0, 2'b01, 2'b01, 0, 0, 16'h1234, 0, 2'b01, 2'b00, 1, 1, 1, 0, 16'h1234, 1, 16'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 1, 0, 0, 0, 16'h1234, 0, 16'h0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 1, 1, 0, 0, 16'h0000, 1, 16'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 1, 0, 0, 0, 16'h0000, 1, 16'h1234));
    tbl.push_back(idle(0, 16'h0000));
    // Same-cycle: r0 writes addr1=5678, r1 reads addr1.
    tbl.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 16'h0, 1, 16'h0));
    tbl.push_back(mk(0, 2'b11, 2'b01, 1, 1, 16'h5678, 0, 2'b01, 2'b00, 1, 1, 1, 1, 16'h5678, 1, 16'h0));
    tbl.push_back(mk(0, 2'b10, 2'b00, 1, 1, 0, 0, 2'b00, 2'b01, 1, 0, 0, 1, 16'h5678, 0, 16'h0));
    tbl.push_back(mk(0, 2'b10, 2'b00, 1, 1, 0, 0, 2'b10, 2'b00, 1, 1, 0, 1, 16'h0000, 1, 16'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 1, 1, 0, 0, 2'b00, 2'b10, 1, 0, 0, 1, 16'h0000, 1, 16'h5678));
    tbl.push_back(idle(1, 16'h0000));
    // Both held for 6 accesses.
    tbl.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 16'h0, 1, 16'h0));
    for (int k = 0; k < 6; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      g_exp = 2'b01;
`else
      g_exp = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      tbl.push_back(mk(0, 2'b11, 2'b00, 1, 1, 0, 0, g_exp, 2'b00, 1, 1, 0, 1, 16'h0, 1, 16'h0));
      tbl.push_back(mk(0, 2'b11, 2'b00, 1, 1, 0, 0, 2'b00, g_exp, 1, 0, 0, 1, 16'h0, 1, 16'h0));
    end
    // Quiet for 5 cycles after an access.
    for (int k = 0; k < 5; k++) tbl.push_back(idle(1, 16'h0000));
    // Reset in the ACCESS cycle of a write BEEF -> addr2, then read addr2.
    tbl.push_back(mk(0, 2'b01, 2'b01, 2, 0, 16'hBEEF, 0, 2'b01, 2'b00, 1, 1, 1, 2, 16'hBEEF, 1, 16'h0));
    tbl.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 16'h0, 1, 16'h0));
    tbl.push_back(idle(0, 16'h0000));
    tbl.push_back(mk(0, 2'b01, 2'b00, 2, 0, 0, 0, 2'b01, 2'b00, 1, 1, 0, 2, 16'h0000, 1, 16'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 2, 0, 0, 0, 2'b00, 2'b01, 1, 0, 0, 2, 16'h0000, 1, 16'h0000));
    tbl.push_back(idle(2, 16'h0000));

    reset = 1'b1; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      reset     = tbl[i].rst;
      req       = tbl[i].rq;
      req_wr    = tbl[i].wr;
      req_addr  = {tbl[i].a1, tbl[i].a0};
      req_wdata = {tbl[i].d1, tbl[i].d0};
      @(posedge clk); #1;
      n_vec++;
      if (gnt !== tbl[i].eg || done !== tbl[i].ed || busy !== tbl[i].eb ||
          reg_sel !== tbl[i].es || reg_wr !== tbl[i].ew ||
          ((tbl[i].es || tbl[i].rst) && (reg_addr !== tbl[i].ea || reg_wdata !== tbl[i].ewd)) ||
          (tbl[i].crd && rsp_rdata !== tbl[i].erd)) begin
        n_bad++;
        $display("FAIL vec%0d: got gnt=%b done=%b busy=%b sel=%b wr=%b addr=%0d wdata=%h rdata=%h, want gnt=%b done=%b busy=%b sel=%b wr=%b addr=%0d wdata=%h rdata=%h",
                 i, gnt, done, busy, reg_sel, reg_wr, reg_addr, reg_wdata, rsp_rdata,
                 tbl[i].eg, tbl[i].ed, tbl[i].eb, tbl[i].es, tbl[i].ew, tbl[i].ea,
                 tbl[i].ewd, tbl[i].erd);
      end
    end

    // Latency from idle: gnt in the first cycle, done in the second.
    reset = 1'b0; req = 2'b10; req_wr = 2'b00; req_addr = {2'd3, 2'd0}; req_wdata = '0;
    @(posedge clk); #1;
    n_vec++;
    if (gnt !== 2'b10) begin
      n_bad++;
      $display("FAIL lat_gnt: got gnt=%b, want 10", gnt);
    end
    req = 2'b00;
    n = 1;
    while (done[1] !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    n_vec++;
    if (done[1] !== 1'b1 || n != 2) begin
      n_bad++;
      $display("FAIL lat_done: done[1] seen at cycle %0d (done=%b), want cycle 2", n, done);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
